mem_controller: RTL and testbench

- Parametrised successor to the single-cycle instruction/data RAM controller.
- Unified BRAM with two ports:
  - instruction fetch port, read-only;
  - data port with load/store request/response handshake.
- Registered (synchronous) reads so the array maps to block RAM.
- Stores use byte enables at the correct byte offset (SB/SH/SW).
- Loads are sign- or zero-extended per RISC-V func3 (LB/LH/LW/LBU/LHU).
- Out-of-range and illegal accesses raise a one-cycle trap.
- Sits between the core pipeline and on-chip memory; drives the core's stall.

---
 rtl/mem_pkg.sv | 23 ++
 rtl/mem_bram_dp.sv | 23 ++
 rtl/mem_controller.sv | 96 +++++++++
 tb/tb_mem_controller.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared func3 codes, enums and lane helpers for the memory controller
// Contents: F3_* width/sign codes, trap_cause_e, state_e, be_mask(), load_ext().
package mem_pkg;
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   typedef enum logic [1:0] {TC_NONE, TC_MISALIGN, TC_RANGE, TC_FUNC3} trap_cause_e;
   typedef enum logic {IDLE, BUSY} state_e;
   // size is func3[1:0]: 0 byte, 1 half, 2 word
   function automatic logic [3:0] be_mask(input logic [1:0] size, input logic [1:0] lane);
      return size == 2'b10 ? 4'b1111 : size == 2'b01 ? 4'b0011 << lane : 4'b0001 << lane;
   endfunction
   function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [2:0] f3, input logic [1:0] lane);
      logic [31:0] s;
      s = word >> {lane, 3'b000};
      return f3 == F3_B  ? {{24{s[7]}}, s[7:0]} :
             f3 == F3_BU ? {24'b0, s[7:0]} :
             f3 == F3_H  ? {{16{s[15]}}, s[15:0]} :
             f3 == F3_HU ? {16'b0, s[15:0]} : word;
   endfunction
endpackage

// File: rtl/mem_bram_dp.sv
// mem_bram_dp: DEPTH x 32 dual-port block RAM, read-first, byte writes on port B
module mem_bram_dp #(
  parameter int    DEPTH     = 1024,
  parameter string INIT_FILE = ""
) (
  input  logic                     clk,
  input  logic                     a_en,
  input  logic [$clog2(DEPTH)-1:0] a_addr,
  output logic [31:0]              a_rdata,
  input  logic                     b_en,
  input  logic [3:0]               b_we,
  input  logic [$clog2(DEPTH)-1:0] b_addr,
  input  logic [31:0]              b_wdata,
  output logic [31:0]              b_rdata
);
  logic [31:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (a_en) a_rdata <= mem[a_addr];
    if (b_en) b_rdata <= mem[b_addr];
    for (int i = 0; i < 4; i++)
      if (b_we[i]) mem[b_addr][8*i +: 8] <= b_wdata[8*i +: 8];
  end
endmodule

// File: rtl/mem_controller.sv
// mem_controller: unified BRAM controller with pipelined fetch port and load/store FSM
// Ports: clk, rst (sync, active-high); fetch if_req/pc -> instruction/if_valid;
// data d_req/d_we/d_func3/d_addr/d_wdata -> d_rdata/d_valid, stall; faults trap_ram/trap_cause.
// Macro MEM_MISALIGN_TRAP_EN: defined, misaligned accesses trap; undefined, low address bits
// are forced to the access alignment and never trap.
module mem_controller import mem_pkg::*; #(
   parameter int          DEPTH     = 1024,
   parameter string       INIT_FILE = "program.hex",
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] pc,
   output logic [31:0] instruction,
   output logic        if_valid,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [2:0]  d_func3,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic [31:0] d_rdata,
   output logic        d_valid,
   output logic        stall,
   output logic        trap_ram,
   output logic [1:0]  trap_cause
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [32:0] SPAN = 33'(DEPTH) << 2;
   logic [31:0] f_off, d_off, a_rdata, b_rdata, wdata, d_rdata_q;
   logic f_mis, d_mis, d_bad, accept, f_seen, f_valid_q, d_valid_q, ld_q;
   logic [1:0] d_lane, lane_q;
   logic [2:0] f3_q;
   logic [3:0] b_we;
   trap_cause_e f_cause, d_cause, cause_q;
   state_e state;
   assign f_off = pc - BASE_ADDR;
   assign d_off = d_addr - BASE_ADDR;
`ifdef MEM_MISALIGN_TRAP_EN
   assign f_mis = f_off[1:0] != 2'b00;
   assign d_mis = (d_func3[1:0] == 2'b01 && d_off[0]) || (d_func3[1:0] == 2'b10 && d_off[1:0] != 2'b00);
`else
   assign f_mis = 1'b0;
   assign d_mis = 1'b0;
`endif
   assign d_bad = d_we ? d_func3 > F3_W : d_func3 == 3'b011 || d_func3[2:1] == 2'b11;
   // A bad func3 has no meaningful width, so it outranks alignment and range
   assign d_cause = d_bad ? TC_FUNC3 : d_mis ? TC_MISALIGN : {1'b0, d_off} >= SPAN ? TC_RANGE : TC_NONE;
   assign f_cause = f_mis ? TC_MISALIGN : {1'b0, f_off} >= SPAN ? TC_RANGE : TC_NONE;
   assign d_lane = d_func3[1:0] == 2'b10 ? 2'b00 : d_func3[1:0] == 2'b01 ? {d_off[1], 1'b0} : d_off[1:0];
   assign accept = state == IDLE && d_req && !rst;
   assign stall = state == IDLE && d_req;
   assign b_we = accept && d_we && d_cause == TC_NONE ? be_mask(d_func3[1:0], d_lane) : 4'b0000;
   assign wdata = d_func3[1:0] == 2'b00 ? {4{d_wdata[7:0]}} : d_func3[1:0] == 2'b01 ? {2{d_wdata[15:0]}} : d_wdata;
   assign instruction = f_seen ? a_rdata : 32'h0;
   assign if_valid = f_valid_q;
   assign d_rdata = d_valid_q && ld_q ? load_ext(b_rdata, f3_q, lane_q) : d_rdata_q;
   // Gating with rst drops a response pending in BUSY when reset arrives
   assign d_valid = d_valid_q && !rst;
   assign trap_ram = cause_q != TC_NONE && !rst;
   assign trap_cause = rst ? 2'b00 : cause_q;
   mem_bram_dp #(.DEPTH(DEPTH), .INIT_FILE(INIT_FILE)) u_bram (
      .clk(clk),
      .a_en(if_req && f_cause == TC_NONE), .a_addr(f_off[AW+1:2]), .a_rdata(a_rdata),
      .b_en(accept), .b_we(b_we), .b_addr(d_off[AW+1:2]), .b_wdata(wdata), .b_rdata(b_rdata)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         f_seen <= 1'b0;
         f_valid_q <= 1'b0;
         d_valid_q <= 1'b0;
         ld_q <= 1'b0;
         f3_q <= 3'b000;
         lane_q <= 2'b00;
         cause_q <= TC_NONE;
         d_rdata_q <= 32'h0;
      end else begin
         f_valid_q <= if_req && f_cause == TC_NONE;
         if (if_req && f_cause == TC_NONE) f_seen <= 1'b1;
         d_rdata_q <= d_rdata;
         // Data fault wins over a simultaneous fetch fault
         cause_q <= accept && d_cause != TC_NONE ? d_cause : if_req ? f_cause : TC_NONE;
         if (state == IDLE) begin
            state <= accept ? BUSY : IDLE;
            d_valid_q <= accept && d_cause == TC_NONE;
            ld_q <= !d_we;
            f3_q <= d_func3;
            lane_q <= d_lane;
         end else begin
            state <= IDLE;
            d_valid_q <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_mem_controller.sv
// tb_mem_controller: directed plus random checks of mem_controller against a byte-level model
module tb_mem_controller;
   import mem_pkg::*;
   localparam int DEPTH = 256;
   localparam logic [31:0] BASE = 32'h0;
`ifdef MEM_MISALIGN_TRAP_EN
   localparam bit MIS = 1'b1;
`else
   localparam bit MIS = 1'b0;
`endif
   logic clk = 1'b0, rst = 1'b1;
   logic if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
   logic [31:0] pc = 32'h0, d_addr = 32'h0, d_wdata = 32'h0;
   logic [2:0] d_func3 = 3'b000;
   logic [31:0] instruction, d_rdata;
   logic if_valid, d_valid, stall, trap_ram;
   logic [1:0] trap_cause;
   int vectors = 0, errors = 0;
   logic [7:0] mb [4*DEPTH];
   logic [31:0] last_rd = 32'h0;

   mem_controller #(.DEPTH(DEPTH), .INIT_FILE(""), .BASE_ADDR(BASE)) dut (
      .clk(clk), .rst(rst), .if_req(if_req), .pc(pc), .instruction(instruction), .if_valid(if_valid),
      .d_req(d_req), .d_we(d_we), .d_func3(d_func3), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_valid(d_valid), .stall(stall), .trap_ram(trap_ram), .trap_cause(trap_cause)
   );
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int fault(input bit we, input int f3, input longint addr);
      int size;
      size = 1 << (f3 % 4);
      if (we ? f3 > 2 : (f3 == 3 || f3 >= 6)) return 3;
      if (MIS && addr % size != 0) return 1;
      if (addr < BASE || addr >= BASE + 4 * DEPTH) return 2;
      return 0;
   endfunction

   function automatic logic [31:0] ld_val(input int f3, input longint addr);
      int size;
      longint a, v;
      size = 1 << (f3 % 4);
      a = addr - addr % size - BASE;
      v = 0;
      for (int i = 0; i < size; i++) v += longint'(mb[a+i]) << (8 * i);
      if (f3 < 4 && size < 4 && v >= (longint'(1) << (8 * size - 1))) v -= longint'(1) << (8 * size);
      return 32'(v);
   endfunction

   task automatic st(input int f3, input longint addr, input logic [31:0] wd);
      int size;
      longint a;
      size = 1 << (f3 % 4);
      a = addr - addr % size - BASE;
      for (int i = 0; i < size; i++) mb[a+i] = wd[8*i +: 8];
   endtask

   task automatic dop(input bit we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
      int c;
      logic [31:0] e;
      c = fault(we, int'(f3), longint'(addr));
      e = (c == 0 && !we) ? ld_val(int'(f3), longint'(addr)) : last_rd;
      d_req = 1'b1; d_we = we; d_func3 = f3; d_addr = addr; d_wdata = wd;
      #1 chk("stall_accept", 32'(stall), 32'd1);
      @(posedge clk); #1;
      d_req = 1'b0;
      chk("d_valid", 32'(d_valid), 32'(c == 0));
      chk("d_rdata", d_rdata, e);
      chk("trap_ram", 32'(trap_ram), 32'(c != 0));
      chk("trap_cause", 32'(trap_cause), 32'(c));
      chk("stall_busy", 32'(stall), 32'd0);
      if (c == 0 && we) st(int'(f3), longint'(addr), wd);
      last_rd = e;
      @(posedge clk); #1;
      chk("d_valid_idle", 32'(d_valid), 32'd0);
   endtask

   task automatic fetch(input logic [31:0] a);
      int c;
      c = fault(1'b0, 2, longint'(a));
      if_req = 1'b1; pc = a;
      @(posedge clk); #1;
      if_req = 1'b0;
      chk("if_valid", 32'(if_valid), 32'(c == 0));
      chk("f_trap", 32'(trap_ram), 32'(c != 0));
      chk("f_cause", 32'(trap_cause), 32'(c));
      if (c == 0) chk("instruction", instruction, ld_val(2, longint'(a)));
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_instruction", instruction, 32'h0);
      chk("rst_if_valid", 32'(if_valid), 32'd0);
      chk("rst_d_rdata", d_rdata, 32'h0);
      chk("rst_d_valid", 32'(d_valid), 32'd0);
      chk("rst_trap", 32'(trap_ram), 32'd0);
      chk("rst_cause", 32'(trap_cause), 32'd0);
      for (int i = 0; i < DEPTH; i++) dop(1'b1, F3_W, 32'(4 * i), $urandom);
      fetch(32'h8);
      fetch(32'h2);
      fetch(32'h400);
      // back-to-back fetches
      for (int i = 0; i < 8; i++) begin
         if_req = 1'b1; pc = 32'(4 * i + 16);
         @(posedge clk); #1;
         chk("burst_valid", 32'(if_valid), 32'd1);
         chk("burst_instr", instruction, ld_val(2, longint'(4 * i + 16)));
      end
      if_req = 1'b0;
      // store sizes
      dop(1'b1, F3_W, 32'h100, 32'hDEADBEEF);
      dop(1'b1, F3_B, 32'h101, 32'h55);
      dop(1'b1, F3_H, 32'h102, 32'hA5A5);
      dop(1'b0, F3_W, 32'h100, 32'h0);
      chk("store_sizes_const", d_rdata, 32'hA5A555EF);
      // load extension
      dop(1'b1, F3_W, 32'h100, 32'h80FF7F80);
      dop(1'b0, F3_B, 32'h100, 32'h0);
      chk("lb_const", d_rdata, 32'hFFFFFF80);
      dop(1'b0, F3_BU, 32'h100, 32'h0);
      dop(1'b0, F3_H, 32'h102, 32'h0);
      chk("lh_const", d_rdata, 32'hFFFF80FF);
      dop(1'b0, F3_HU, 32'h102, 32'h0);
      for (int i = 0; i < 4; i++) dop(1'b0, F3_B, 32'(32'h100 + i), 32'h0);
      // handshake with d_req held for two loads
      d_req = 1'b1; d_we = 1'b0; d_func3 = F3_W; d_addr = 32'h100;
      #1 chk("hs_stall1", 32'(stall), 32'd1);
      @(posedge clk); #1;
      chk("hs_valid1", 32'(d_valid), 32'd1);
      chk("hs_rdata1", d_rdata, ld_val(2, 32'h100));
      chk("hs_busy_stall", 32'(stall), 32'd0);
      d_addr = 32'h8;
      @(posedge clk); #1;
      chk("hs_gap", 32'(d_valid), 32'd0);
      chk("hs_stall2", 32'(stall), 32'd1);
      @(posedge clk); #1;
      d_req = 1'b0;
      chk("hs_valid2", 32'(d_valid), 32'd1);
      chk("hs_rdata2", d_rdata, ld_val(2, 32'h8));
      last_rd = ld_val(2, 32'h8);
      @(posedge clk); #1;
      // faults
      dop(1'b1, F3_W, 32'(BASE + 4 * DEPTH), 32'h12345678);
      dop(1'b0, F3_W, 32'h0, 32'h0);
      dop(1'b0, 3'b011, 32'h100, 32'h0);
      dop(1'b0, F3_W, 32'h102, 32'h0);
      dop(1'b1, F3_H, 32'h103, 32'hBEEF);
      dop(1'b0, F3_W, 32'h100, 32'h0);
      // fetch and data fault together: data cause wins
      if_req = 1'b1; pc = 32'h800; d_req = 1'b1; d_we = 1'b0; d_func3 = 3'b111; d_addr = 32'h0;
      @(posedge clk); #1;
      if_req = 1'b0; d_req = 1'b0;
      chk("both_cause", 32'(trap_cause), 32'd3);
      chk("both_if_valid", 32'(if_valid), 32'd0);
      @(posedge clk); #1;
      // same-word store and fetch: fetch sees old data
      if_req = 1'b1; pc = 32'h40; d_req = 1'b1; d_we = 1'b1; d_func3 = F3_W; d_addr = 32'h40; d_wdata = 32'hC0FFEE11;
      begin
         logic [31:0] old;
         old = ld_val(2, 32'h40);
         @(posedge clk); #1;
         if_req = 1'b0; d_req = 1'b0;
         chk("collide_old", instruction, old);
      end
      st(2, 32'h40, 32'hC0FFEE11);
      @(posedge clk); #1;
      dop(1'b0, F3_W, 32'h40, 32'h0);
      fetch(32'h40);
      // reset while BUSY
      d_req = 1'b1; d_we = 1'b0; d_func3 = F3_W; d_addr = 32'h100;
      @(posedge clk); #1;
      d_req = 1'b0; rst = 1'b1;
      #1 chk("rst_busy_valid", 32'(d_valid), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      last_rd = 32'h0;
      chk("rst_after_valid", 32'(d_valid), 32'd0);
      chk("rst_after_rdata", d_rdata, 32'h0);
      d_req = 1'b1;
      #1 chk("rst_idle_stall", 32'(stall), 32'd1);
      d_req = 1'b0;
      // store presented on a reset edge is blocked
      rst = 1'b1; d_req = 1'b1; d_we = 1'b1; d_func3 = F3_W; d_addr = 32'h104; d_wdata = 32'h12345678;
      @(posedge clk); #1;
      rst = 1'b0; d_req = 1'b0;
      chk("rst_store_valid", 32'(d_valid), 32'd0);
      dop(1'b0, F3_W, 32'h104, 32'h0);
      // random traffic
      for (int n = 0; n < 300; n++) begin
         logic [31:0] a;
         a = $urandom_range(0, 9) == 0 ? 32'(32'h400 + $urandom_range(0, 15)) : 32'($urandom_range(0, 1023));
         if ($urandom_range(0, 4) == 0) fetch(a);
         else dop(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
